// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//   Sprite DMA sequencer on the CPU memory bus. A CPU write to DMA_REG_ADDR
//   halts the CPU and copies XFER_LEN bytes from page {cpu_wdata, 8'h00} to the
//   PPU OAM data port at OAM_DATA_ADDR, one read/write pair per byte. The block
//   sits between the CPU core and the CPU-side address mapper. It owns the
//   mapper's addr/WE/wdata while a transfer is running. Otherwise it passes
//   the CPU through unchanged.
//
// Parameters
//   DMA_REG_ADDR   CPU address that triggers a transfer (write only)
//   OAM_DATA_ADDR  destination address, written once per byte
//   XFER_LEN       bytes per transfer, legal range 1..256
//
// Ports
//   clk         in   1   system clock, single domain
//   reset       in   1   synchronous, active-high reset
//   cpu_addr    in   16  CPU address
//   cpu_wdata   in   8   CPU write data
//   cpu_WE      in   1   CPU write enable
//   bus_rdata   in   8   mapper read data, combinational from bus_addr
//   bus_addr    out  16  address to mapper
//   bus_wdata   out  8   write data to mapper
//   bus_WE      out  1   write enable to mapper
//   cpu_rdy     out  1   1 = CPU may advance, 0 = CPU halted
//   dma_active  out  1   1 while the controller owns the bus
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_WE,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_WE,
  output logic        cpu_rdy,
  output logic        dma_active
);

  // Index of the final byte. The counter is 9 bits so that XFER_LEN=256 fits
  // without the compare wrapping to zero.
  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  page_r;
  logic [8:0]  byte_cnt_r;
  logic [7:0]  data_latch_r;
  logic        parity_r;
  logic        trigger_s;

  // A trigger is honoured only from IDLE. Writes to the DMA register during a
  // transfer are ignored, so they cannot restart the transfer or move the page.
  assign trigger_s = (state_r == ST_IDLE) && cpu_WE && (cpu_addr == DMA_REG_ADDR);

  // Sequencer state, source page, byte counter, read latch and the cycle-parity flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      page_r       <= 8'h00;
      byte_cnt_r   <= 9'd0;
      data_latch_r <= 8'h00;
      parity_r     <= 1'b0;
    end else begin
      // Free-running parity decides whether an extra alignment cycle is
      // needed so that the read/write pairs land on a fixed cycle phase.
      parity_r <= ~parity_r;
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            page_r     <= cpu_wdata;
            byte_cnt_r <= 9'd0;
            state_r    <= ST_HALT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (parity_r) begin
            state_r <= ST_ALIGN;
          end else begin
            state_r <= ST_READ;
          end
        end
        ST_ALIGN: begin
          state_r <= ST_READ;
        end
        ST_READ: begin
          data_latch_r <= bus_rdata;
          state_r      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (byte_cnt_r == LAST_IDX) begin
            state_r    <= ST_IDLE;
          end else begin
            byte_cnt_r <= byte_cnt_r + 9'd1;
            state_r    <= ST_READ;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus steering and CPU halt, decoded directly from state. Outside IDLE, CPU
  // write data and write enables never reach the mapper.
  always_comb begin
    bus_addr   = cpu_addr;
    bus_wdata  = cpu_wdata;
    bus_WE     = cpu_WE;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus_addr   = cpu_addr;
        bus_wdata  = cpu_wdata;
        bus_WE     = cpu_WE;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
      end
      ST_HALT, ST_ALIGN: begin
        bus_addr   = cpu_addr;
        bus_wdata  = data_latch_r;
        bus_WE     = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      ST_READ: begin
        // Only the low byte walks, so the source never carries into page+1.
        bus_addr   = {page_r, byte_cnt_r[7:0]};
        bus_wdata  = data_latch_r;
        bus_WE     = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      ST_WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_wdata  = data_latch_r;
        bus_WE     = 1'b1;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      default: begin
        bus_addr   = cpu_addr;
        bus_wdata  = cpu_wdata;
        bus_WE     = 1'b0;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_ctrl
//   Directed bench for oam_dma_ctrl. A behavioural 64 KiB memory answers bus
//   reads combinationally. A negedge monitor logs OAM writes, source reads,
//   cpu_rdy activity and any stray DMA writes. The directed tests compare
//   those logs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

  localparam logic [15:0] OAM_ADDR  = 16'h2004;
  localparam logic [15:0] DMA_ADDR  = 16'h4014;
  // CPU address held while a transfer runs. It is chosen outside every source
  // page so that a READ cycle is distinguishable from HALT/ALIGN.
  localparam logic [15:0] PARK_ADDR = 16'hC000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_WE;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_WE;
  logic        cpu_rdy;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  oam_dma_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_WE     (cpu_WE),
    .bus_rdata  (bus_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_WE     (bus_WE),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr];

  // Cycle counter, plus the expected cycle parity (cleared by reset, toggles every clock).
  int   cyc    = 0;
  logic tb_par = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_par <= reset ? 1'b0 : ~tb_par;
  end

  // Monitor logs.
  logic [7:0]  oam_q[$];
  int          oam_cyc_q[$];
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  int          rise_cyc_q[$];
  int          rdy_low_total = 0;
  int          bad_wr_total  = 0;
  int          oam_any_total = 0;
  logic        prev_rdy      = 1'b1;

  // Sample bus activity mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!cpu_rdy) rdy_low_total <= rdy_low_total + 1;
    if (bus_WE && bus_addr == OAM_ADDR) begin
      oam_any_total <= oam_any_total + 1;
      if (dma_active) begin
        oam_q.push_back(bus_wdata);
        oam_cyc_q.push_back(cyc);
      end
    end
    if (dma_active && bus_WE && bus_addr != OAM_ADDR) bad_wr_total <= bad_wr_total + 1;
    if (dma_active && !bus_WE && bus_addr != cpu_addr) begin
      rd_q.push_back(bus_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (cpu_rdy && !prev_rdy) rise_cyc_q.push_back(cyc);
    prev_rdy <= cpu_rdy;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int s_oam, s_rd, s_low, s_bad, s_rise, s_any, trig_cyc;

  task automatic snap();
    s_oam  = oam_q.size();
    s_rd   = rd_q.size();
    s_low  = rdy_low_total;
    s_bad  = bad_wr_total;
    s_rise = rise_cyc_q.size();
    s_any  = oam_any_total;
  endtask

  // Trigger a transfer so that the HALT cycle sees parity == align.
  task automatic start_dma(input logic [7:0] page, input logic align);
    int guard = 0;
    cpu_WE   = 1'b0;
    cpu_addr = PARK_ADDR;
    while (tb_par != !align && guard < 4) begin
      step();
      guard++;
    end
    cpu_addr  = DMA_ADDR;
    cpu_wdata = page;
    cpu_WE    = 1'b1;
    trig_cyc  = cyc;
    step();
    cpu_addr  = PARK_ADDR;
    cpu_wdata = 8'h00;
    cpu_WE    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active && n < 700) begin
      step();
      n++;
    end
    check_eq(tag, {31'd0, dma_active}, 32'd0);
    step();  // let the monitor log the cpu_rdy rising cycle
  endtask

  task automatic verify_xfer(input string pfx, input int exp_low, input logic [7:0] page,
                             input logic [7:0] key);
    int errs;
    int gap;
    check_eq({pfx, "_rdy_low"}, rdy_low_total - s_low, exp_low);
    check_eq({pfx, "_oam_cnt"}, oam_q.size() - s_oam, 32'd256);
    check_eq({pfx, "_rd_cnt"}, rd_q.size() - s_rd, 32'd256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (s_oam + i < oam_q.size()) begin
        if (oam_q[s_oam + i] !== (i[7:0] ^ key)) errs++;
      end
      if (s_rd + i < rd_q.size()) begin
        if (rd_q[s_rd + i] !== {page, i[7:0]}) errs++;
      end
    end
    check_eq({pfx, "_data_addr_errs"}, errs, 32'd0);
    check_eq({pfx, "_stray_wr"}, bad_wr_total - s_bad, 32'd0);
    gap = -1;
    if (rise_cyc_q.size() > s_rise && oam_cyc_q.size() > s_oam) gap = rise_cyc_q[s_rise] - oam_cyc_q[$];
    check_eq({pfx, "_rdy_after_last_wr"}, gap, 32'd1);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = i[7:0] ^ 8'hA5;
      mem[16'h8000 + i] = i[7:0] ^ 8'h5A;
    end
    reset     = 1'b1;
    cpu_addr  = 16'h1111;
    cpu_wdata = 8'h22;
    cpu_WE    = 1'b0;
    step();
    step();
    // Reset state: pass-through.
    check_eq("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_eq("rst_active", {31'd0, dma_active}, 32'd0);
    check_eq("rst_addr", {16'd0, bus_addr}, 32'h1111);
    check_eq("rst_wdata", {24'd0, bus_wdata}, 32'h22);
    check_eq("rst_we", {31'd0, bus_WE}, 32'd0);
    reset = 1'b0;
    step();

    // 1: page 02, no alignment cycle.
    snap();
    start_dma(8'h02, 1'b0);
    wait_idle("t1_done");
    verify_xfer("t1", 513, 8'h02, 8'hA5);
    check_eq("t1_first_rd", (rd_cyc_q.size() > s_rd) ? rd_cyc_q[s_rd] - trig_cyc : -1, 32'd2);
    step();

    // 2: same transfer with an alignment cycle.
    snap();
    start_dma(8'h02, 1'b1);
    wait_idle("t2_done");
    verify_xfer("t2", 514, 8'h02, 8'hA5);
    check_eq("t2_first_rd", (rd_cyc_q.size() > s_rd) ? rd_cyc_q[s_rd] - trig_cyc : -1, 32'd3);

    // 3: page 80 (PRG ROM); reads $8000..$80FF and no carry into $81xx.
    snap();
    start_dma(8'h80, 1'b0);
    wait_idle("t3_done");
    verify_xfer("t3", 513, 8'h80, 8'h5A);

    // 4: retrigger at byte 10 is ignored.
    snap();
    start_dma(8'h02, 1'b0);
    n = 0;
    while ((oam_q.size() - s_oam) < 10 && n < 700) begin
      step();
      n++;
    end
    check_eq("t4_reach_byte10", oam_q.size() - s_oam, 32'd10);
    cpu_addr  = DMA_ADDR;
    cpu_wdata = 8'h05;
    cpu_WE    = 1'b1;
    step();
    cpu_addr  = PARK_ADDR;
    cpu_wdata = 8'h00;
    cpu_WE    = 1'b0;
    wait_idle("t4_done");
    verify_xfer("t4", 513, 8'h02, 8'hA5);

    // 5: reset in the WRITE cycle of byte 100.
    snap();
    start_dma(8'h02, 1'b0);
    n = 0;
    while (!((oam_q.size() - s_oam) == 100 && bus_WE && bus_addr == OAM_ADDR) && n < 700) begin
      step();
      n++;
    end
    check_eq("t5_reach_byte100", oam_q.size() - s_oam, 32'd100);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    cpu_addr  = 16'h0300;
    cpu_wdata = 8'h5C;
    cpu_WE    = 1'b1;
    #1;
    check_eq("t5_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_eq("t5_active", {31'd0, dma_active}, 32'd0);
    check_eq("t5_addr", {16'd0, bus_addr}, 32'h0300);
    check_eq("t5_we", {31'd0, bus_WE}, 32'd1);
    step();
    cpu_WE   = 1'b0;
    cpu_addr = PARK_ADDR;
    for (int i = 0; i < 600; i++) step();
    check_eq("t5_oam_total", oam_any_total - s_any, 32'd101);
    check_eq("t5_still_idle", {31'd0, dma_active}, 32'd0);

    // Trigger in the same cycle as reset is discarded.
    reset     = 1'b1;
    cpu_addr  = DMA_ADDR;
    cpu_wdata = 8'h02;
    cpu_WE    = 1'b1;
    step();
    reset    = 1'b0;
    cpu_WE   = 1'b0;
    cpu_addr = PARK_ADDR;
    step();
    step();
    check_eq("rst_trig_active", {31'd0, dma_active}, 32'd0);
    check_eq("rst_trig_rdy", {31'd0, cpu_rdy}, 32'd1);

    // 6: CPU writes to $2004 and $4015 in IDLE pass straight through.
    cpu_addr  = 16'h2004;
    cpu_wdata = 8'h3C;
    cpu_WE    = 1'b1;
    #1;
    check_eq("t6_2004_addr", {16'd0, bus_addr}, 32'h2004);
    check_eq("t6_2004_wdata", {24'd0, bus_wdata}, 32'h3C);
    check_eq("t6_2004_we", {31'd0, bus_WE}, 32'd1);
    check_eq("t6_2004_rdy", {31'd0, cpu_rdy}, 32'd1);
    step();
    cpu_addr  = 16'h4015;
    cpu_wdata = 8'h81;
    #1;
    check_eq("t6_4015_addr", {16'd0, bus_addr}, 32'h4015);
    check_eq("t6_4015_wdata", {24'd0, bus_wdata}, 32'h81);
    check_eq("t6_4015_we", {31'd0, bus_WE}, 32'd1);
    step();
    cpu_WE = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("t6_no_dma", {31'd0, dma_active}, 32'd0);
    check_eq("t6_rdy", {31'd0, cpu_rdy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
